dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache controller between the MEM stage and off-chip data memory. It serves CPU loads and stores from a 32-line cache and runs line refills and dirty evictions over a request/ack memory port. It generates the single pipeline stall that freezes every pipeline register, the MEM/WB register included, until the access completes.

## Interface
Parameters:
- LINES, 32, number of cache lines (index width 5)
- LINE_W, 256, line width in bits (8 words, 32 bytes)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- p1_addr_i  in  32  byte address: tag [31:10], index [9:5], word [4:2], [1:0] ignored
- p1_data_i  in  32  store data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request
- p1_data_o  out  32  load data; word [4:2] of the indexed line, combinational
- p1_stall_o  out  1  freeze pipeline; combinational
- mem_addr_o  out  32  line address, bits [4:0] = 0
- mem_data_o  out  256  eviction line data
- mem_enable_o  out  1  memory request valid
- mem_write_o  out  1  1 = line write (evict), 0 = line read (refill)
- mem_data_i  in  256  refill data, valid when mem_ack_i = 1
- mem_ack_i  in  1  one-cycle completion pulse

## Operation
- req = p1_MemRead_i | p1_MemWrite_i. If both are high, the access is treated as a store.
- hit = valid[index] & (tag[index] == addr[31:10]).
- Tag entry per line: valid, dirty, 22-bit tag. The data array is not reset.
- States:
  - IDLE
    - req & hit, load: p1_data_o is valid in the same cycle.
    - req & hit, store: the selected word is written and dirty is set at the next edge.
    - req & ~hit: go to MISS.
    - no req: stay in IDLE.
  - MISS (no memory request this cycle): if valid & dirty, go to WRITEBACK; otherwise go to READMISS.
  - WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {old tag, index, 5'b0}, mem_data_o = the stored line. On mem_ack_i: clear dirty, go to MISS.
  - READMISS: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {addr[31:5], 5'b0}. On mem_ack_i: write mem_data_i into the line, tag = addr[31:10], valid = 1, dirty = 0, go to READMISSOK.
  - READMISSOK: go to IDLE, where the access replays as a hit. A store miss therefore writes its word in IDLE and sets dirty.
- p1_stall_o = (state == IDLE) ? (req & ~hit) : 1.
- mem_enable_o and mem_write_o are 0 outside WRITEBACK and READMISS. mem_addr_o and mem_data_o are held stable throughout a transaction.

## Timing
- Hit latency: 0 cycles, no stall.
- Clean miss, with N = cycles from request to ack:
  - 1 cycle in MISS, N in READMISS, 1 in READMISSOK.
  - p1_stall_o falls combinationally in the first IDLE cycle.
- Dirty miss: adds 1 cycle in MISS plus the writeback latency.
- After every ack, mem_enable_o is low for exactly one cycle before the next request. Memory may rely on this gap.
- The CPU must hold p1_* stable while p1_stall_o = 1. The controller latches nothing from the CPU and re-evaluates from the live inputs.
- Reset:
  - state = IDLE, all valid = 0, all dirty = 0.
  - mem_enable_o = 0 and mem_write_o = 0 immediately, without waiting for a clock edge.
  - p1_stall_o = req.
  - Reset mid-transaction abandons it; dirty data is lost. An ack arriving after reset is ignored in IDLE.
- An ack is ignored in IDLE, MISS and READMISSOK.

## Structure
- Package dcache_pkg holds:
  - state enum {IDLE, MISS, WRITEBACK, READMISS, READMISSOK}
  - TAG_W = 22, IDX_W = 5, OFF_W = 5, LINE_W = 256
  - tag entry struct {valid, dirty, tag}
- Sub-module dcache_sram holds the tag and data arrays:
  - asynchronous read
  - synchronous write with per-line full-write and per-word write enables
  - valid/dirty bits cleared by rst_i
- dcache_ctrl holds the FSM, hit logic, word select/merge and memory port.

## Test plan
The memory model acks 10 cycles after enable.
- Reset, then load 0x0000_0004 with line word1 = 0xDEADBEEF:
  - p1_stall_o = 1
  - READMISS with mem_addr_o = 0x0000_0000, write = 0
  - p1_stall_o falls 2 cycles after the ack cycle
  - p1_data_o = 0xDEADBEEF
- Store 0x1234_5678 to 0x0000_0008 (hit): no stall; a following load of 0x0000_0008 returns 0x1234_5678 with no stall.
- Load 0x0000_0408 (same index 0, tag 1) after the step above:
  - WRITEBACK with mem_addr_o = 0x0000_0000, write = 1, mem_data_o word2 = 0x1234_5678
  - mem_enable_o low for 1 cycle
  - READMISS with mem_addr_o = 0x0000_0400
- Store miss to clean line 0x0000_0020:
  - no WRITEBACK
  - refill from 0x0000_0020, then the word is written and dirty is set
  - evicting it later produces a WRITEBACK
- rst_i pulsed mid-WRITEBACK:
  - mem_enable_o drops asynchronously
  - the following load of 0x0000_0000 misses, because all lines are invalid
- MemRead = MemWrite = 0 for 20 cycles: p1_stall_o = 0 and mem_enable_o = 0 throughout.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped L1 data cache.
// Address split: tag [31:10], index [9:5], word [4:2].
package dcache_pkg;

  localparam int TAG_W  = 22;
  localparam int IDX_W  = 5;
  localparam int OFF_W  = 5;
  localparam int LINE_W = 256;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag and data arrays: async read, sync write.
// Only valid/dirty are reset; tags and data are left as-is.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              fill_we_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_data_i,
  input  logic              word_we_i,
  input  logic [2:0]        word_sel_i,
  input  logic [31:0]       word_data_i,
  input  logic              clean_we_i,
  output tag_entry_t        entry_o,
  output logic [LINE_W-1:0] line_o
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (clean_we_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_sel_i, 5'b0} +: 32] <= word_data_i;
    end
  end

  assign entry_o.valid = valid_q[idx_i];
  assign entry_o.dirty = dirty_q[idx_i];
  assign entry_o.tag   = tag_q[idx_i];
  assign line_o        = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate L1 D-cache controller: hit path,
// miss FSM and line-wide request/ack memory port.
module dcache_ctrl #(
  parameter int LINES  = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  import dcache_pkg::*;

  state_e            state_q;
  logic              en_q;
  logic              wr_q;
  logic [31:0]       addr_q;
  tag_entry_t        ent;
  logic [LINE_W-1:0] line;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [2:0]        word;
  logic              req;
  logic              hit;
  logic              fill_we;
  logic              word_we;
  logic              clean_we;
  logic              unused_ok;

  assign idx       = p1_addr_i[9:5];
  assign tag       = p1_addr_i[31:10];
  assign word      = p1_addr_i[4:2];
  assign unused_ok = ^p1_addr_i[1:0];

  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign hit = ent.valid && (ent.tag == tag);

  assign fill_we  = (state_q == READMISS) && mem_ack_i;
  assign clean_we = (state_q == WRITEBACK) && mem_ack_i;
  // Store misses replay here as hits once the line is in.
  assign word_we  = (state_q == IDLE) && p1_MemWrite_i && hit;

  dcache_sram #(
    .LINES(LINES)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (idx),
    .fill_we_i   (fill_we),
    .fill_tag_i  (tag),
    .fill_data_i (mem_data_i),
    .word_we_i   (word_we),
    .word_sel_i  (word),
    .word_data_i (p1_data_i),
    .clean_we_i  (clean_we),
    .entry_o     (ent),
    .line_o      (line)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req && !hit) state_q <= MISS;
        end
        MISS: begin
          en_q <= 1'b1;
          if (ent.valid && ent.dirty) begin
            state_q <= WRITEBACK;
            wr_q    <= 1'b1;
            addr_q  <= {ent.tag, idx, 5'b0};
          end else begin
            state_q <= READMISS;
            wr_q    <= 1'b0;
            addr_q  <= {p1_addr_i[31:5], 5'b0};
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state_q <= MISS;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
          end
        end
        READMISS: begin
          if (mem_ack_i) begin
            state_q <= READMISSOK;
            en_q    <= 1'b0;
          end
        end
        READMISSOK: state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  assign p1_data_o    = line[{word, 5'b0} +: 32];
  assign p1_stall_o   = (state_q == IDLE) ? (req & ~hit) : 1'b1;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = line;
  assign mem_enable_o = en_q;
  assign mem_write_o  = wr_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: line-level cache/memory model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  p1_addr = '0;
  logic [31:0]  p1_wdata = '0;
  logic         p1_rd = 1'b0;
  logic         p1_wr = 1'b0;
  logic [31:0]  p1_rdata;
  logic         stall;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_en;
  logic         mem_we;
  logic         mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .p1_addr_i     (p1_addr),
    .p1_data_i     (p1_wdata),
    .p1_MemRead_i  (p1_rd),
    .p1_MemWrite_i (p1_wr),
    .p1_data_o     (p1_rdata),
    .p1_stall_o    (stall),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_wdata),
    .mem_enable_o  (mem_en),
    .mem_write_o   (mem_we),
    .mem_data_i    (mem_rdata),
    .mem_ack_i     (mem_ack)
  );

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input int la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = 32'h1000_0000 + 32'(la * 8 + w);
    return l;
  endfunction

  // Off-chip memory: acks 10 cycles after enable is seen.
  logic [255:0] ram [int];
  int mcnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst || !mem_en || mem_ack) begin
      mem_ack = 1'b0;
      mcnt = 0;
    end else begin
      mcnt++;
      if (mcnt == 10) begin
        if (mem_we) ram[int'(mem_addr[31:5])] = mem_wdata;
        else if (ram.exists(int'(mem_addr[31:5])))
          mem_rdata = ram[int'(mem_addr[31:5])];
        else mem_rdata = init_line(int'(mem_addr[31:5]));
        mem_ack = 1'b1;
      end
    end
  end

  // Reference model: cache contents and backing store per line.
  logic         mvalid [32];
  logic         mdirty [32];
  logic [21:0]  mtag   [32];
  logic [255:0] mline  [32];
  logic [255:0] mmem   [int];
  bit           post_fill = 1'b0;

  function automatic logic [255:0] mem_get(input int la);
    if (mmem.exists(la)) return mmem[la];
    return init_line(la);
  endfunction

  always @(negedge clk) begin : cmp
    logic       req;
    logic       mh;
    logic       wb;
    logic [4:0] i;
    logic [2:0] w;
    bit         nxt_pf;
    req = p1_rd | p1_wr;
    i   = p1_addr[9:5];
    w   = p1_addr[4:2];
    mh  = mvalid[i] && (mtag[i] == p1_addr[31:10]);
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        mvalid[k] = 1'b0;
        mdirty[k] = 1'b0;
      end
      post_fill = 1'b0;
      chk("rst_stall", 256'(stall), 256'(req));
      chk("rst_enable", 256'(mem_en), 256'(0));
    end else begin
      chk("stall", 256'(stall), 256'(post_fill || (req && !mh)));
      if (!req) chk("idle_enable", 256'(mem_en), 256'(0));
      wb = mvalid[i] && mdirty[i] && !mh;
      if (mem_en) begin
        chk("mem_write", 256'(mem_we), 256'(wb));
        if (wb) begin
          chk("wb_addr", 256'(mem_addr), 256'({mtag[i], i, 5'b0}));
          chk("wb_data", mem_wdata, mline[i]);
        end else begin
          chk("rd_addr", 256'(mem_addr), 256'({p1_addr[31:5], 5'b0}));
        end
      end
      if (!stall && p1_rd && !p1_wr)
        chk("load_data", 256'(p1_rdata), 256'(mline[i][{w, 5'b0} +: 32]));
      nxt_pf = 1'b0;
      if (mem_en && mem_ack) begin
        if (wb) begin
          mmem[int'({mtag[i], i})] = mline[i];
          mdirty[i] = 1'b0;
        end else begin
          mline[i]  = mem_get(int'(p1_addr[31:5]));
          mtag[i]   = p1_addr[31:10];
          mvalid[i] = 1'b1;
          mdirty[i] = 1'b0;
          nxt_pf    = 1'b1;
        end
      end
      if (!stall && p1_wr && mh) begin
        mline[i][{w, 5'b0} +: 32] = p1_wdata;
        mdirty[i] = 1'b1;
      end
      post_fill = nxt_pf;
    end
  end

  task automatic drive(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    p1_rd = rd;
    p1_wr = wr;
    p1_addr = a;
    p1_wdata = d;
    #1;
  endtask

  // which: 0 = mem_enable, 1 = mem_ack, 2 = stall
  task automatic wait_sig(input int which, input logic val,
                          input string nm, output int n);
    logic cur;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
      cur = (which == 0) ? mem_en : (which == 1) ? mem_ack : stall;
    end while (cur !== val && n < 100);
    if (cur !== val) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout got %b expected %b", nm, cur, val);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : directed
    logic [255:0] l0;
    int n;
    l0 = init_line(0);
    l0[63:32] = 32'hDEAD_BEEF;
    ram[0] = l0;
    mmem[0] = l0;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_stall", 256'(stall), 256'(0));
    chk("reset_enable", 256'(mem_en), 256'(0));
    #1 rst = 1'b0;

    // Clean miss from reset
    drive(1'b1, 1'b0, 32'h0000_0004, '0);
    chk("t1_stall", 256'(stall), 256'(1));
    wait_sig(0, 1'b1, "t1_en", n);
    chk("t1_write", 256'(mem_we), 256'(0));
    chk("t1_addr", 256'(mem_addr), 256'(32'h0000_0000));
    wait_sig(1, 1'b1, "t1_ack", n);
    wait_sig(2, 1'b0, "t1_stall_fall", n);
    chk("t1_stall_delay", 256'(n), 256'(2));
    chk("t1_data", 256'(p1_rdata), 256'(32'hDEAD_BEEF));

    // Store hit then load back
    drive(1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678);
    chk("t2_store_stall", 256'(stall), 256'(0));
    drive(1'b1, 1'b0, 32'h0000_0008, '0);
    chk("t2_load_stall", 256'(stall), 256'(0));
    chk("t2_data", 256'(p1_rdata), 256'(32'h1234_5678));

    // Dirty conflict miss
    drive(1'b1, 1'b0, 32'h0000_0408, '0);
    wait_sig(0, 1'b1, "t3_en", n);
    chk("t3_wb_write", 256'(mem_we), 256'(1));
    chk("t3_wb_addr", 256'(mem_addr), 256'(32'h0000_0000));
    chk("t3_wb_word2", 256'(mem_wdata[95:64]), 256'(32'h1234_5678));
    wait_sig(1, 1'b1, "t3_ack", n);
    wait_sig(0, 1'b1, "t3_en2", n);
    chk("t3_gap", 256'(n), 256'(2));
    chk("t3_rd_write", 256'(mem_we), 256'(0));
    chk("t3_rd_addr", 256'(mem_addr), 256'(32'h0000_0400));
    wait_sig(2, 1'b0, "t3_done", n);
    chk("t3_data", 256'(p1_rdata), 256'(32'h1000_0102));

    // Store miss to an invalid line, then evict it
    drive(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    wait_sig(0, 1'b1, "t4_en", n);
    chk("t4_write", 256'(mem_we), 256'(0));
    chk("t4_addr", 256'(mem_addr), 256'(32'h0000_0020));
    wait_sig(2, 1'b0, "t4_done", n);
    drive(1'b1, 1'b0, 32'h0000_0020, '0);
    chk("t4_data", 256'(p1_rdata), 256'(32'hCAFE_F00D));
    drive(1'b1, 1'b0, 32'h0000_0420, '0);
    wait_sig(0, 1'b1, "t4_ev_en", n);
    chk("t4_ev_write", 256'(mem_we), 256'(1));
    chk("t4_ev_addr", 256'(mem_addr), 256'(32'h0000_0020));
    chk("t4_ev_word0", 256'(mem_wdata[31:0]), 256'(32'hCAFE_F00D));
    wait_sig(2, 1'b0, "t4_ev_done", n);
    chk("t4_ev_data", 256'(p1_rdata), 256'(32'h1000_0108));

    // Reset in the middle of a writeback
    drive(1'b0, 1'b1, 32'h0000_0424, 32'h55AA_55AA);
    drive(1'b1, 1'b0, 32'h0000_0024, '0);
    wait_sig(0, 1'b1, "t5_en", n);
    chk("t5_wb_write", 256'(mem_we), 256'(1));
    chk("t5_wb_addr", 256'(mem_addr), 256'(32'h0000_0420));
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    p1_rd = 1'b0;
    #1;
    chk("t5_async_en", 256'(mem_en), 256'(0));
    chk("t5_async_wr", 256'(mem_we), 256'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0000, '0);
    chk("t5_post_rst_miss", 256'(stall), 256'(1));
    wait_sig(2, 1'b0, "t5_done", n);
    chk("t5_data", 256'(p1_rdata), 256'(32'h1000_0000));

    // No requests for 20 cycles
    drive(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #2;
      chk("t6_stall", 256'(stall), 256'(0));
      chk("t6_enable", 256'(mem_en), 256'(0));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
